// File: rtl/usb_mem_arbiter.sv
// Round-robin arbiter between the AXI bridge and the host-controller DMA for the UHCI
// buffer-memory port, with burst locking, forced burst cut and tagged read return.
module usb_mem_arbiter #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 4
) (
   input  logic              Clk_UHCI,
   input  logic              Rst_UHCI,
   input  logic              br_req,
   input  logic              br_we,
   input  logic [ADDR_W-1:0] br_addr,
   input  logic [DATA_W-1:0] br_wdata,
   output logic              br_gnt,
   output logic              br_rvalid,
   output logic [DATA_W-1:0] br_rdata,
   input  logic              hc_req,
   input  logic              hc_we,
   input  logic              hc_last,
   input  logic [ADDR_W-1:0] hc_addr,
   input  logic [DATA_W-1:0] hc_wdata,
   output logic              hc_gnt,
   output logic              hc_rvalid,
   output logic [DATA_W-1:0] hc_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              burst_cut
);

   typedef enum logic {IDLE, HC_LOCK} state_t;

   localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

   state_t            state_q, state_d;
   logic              prio_q, prio_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [3:0]        cnt_inc;
   logic              cut_d, burst_cut_q;
   logic              br_gnt_c, hc_gnt_c, gnt_any, we_sel;
   logic              mem_en_q, mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              rd1_q, own1_q, rd2_q, own2_q;
   logic              busy_q;

   always_comb begin
      state_d  = state_q;
      prio_d   = prio_q;
      cnt_d    = cnt_q;
      cut_d    = 1'b0;
      br_gnt_c = 1'b0;
      hc_gnt_c = 1'b0;
      cnt_inc  = cnt_q + 4'd1;
      if (state_q == IDLE) begin
         if (br_req && (!hc_req || !prio_q)) begin
            br_gnt_c = 1'b1;
            prio_d   = 1'b1;
         end else if (hc_req) begin
            hc_gnt_c = 1'b1;
            if (hc_last || MAX_BURST == 1) begin
               prio_d = 1'b0;
            end else begin
               state_d = HC_LOCK;
               cnt_d   = 4'd1;
            end
         end
      end else begin
         // While locked the bridge is shut out; any hole, last beat or full burst unlocks.
         if (hc_req) begin
            hc_gnt_c = 1'b1;
            cnt_d    = cnt_inc;
            if (hc_last || cnt_inc == MAX_CNT) begin
               state_d = IDLE;
               prio_d  = 1'b0;
               cnt_d   = 4'd0;
               cut_d   = !hc_last;
            end
         end else begin
            state_d = IDLE;
            prio_d  = 1'b0;
            cnt_d   = 4'd0;
         end
      end
   end

   assign gnt_any = br_gnt_c | hc_gnt_c;
   assign we_sel  = br_gnt_c ? br_we : hc_we;

   always_ff @(posedge Clk_UHCI or negedge Rst_UHCI) begin
      if (!Rst_UHCI) begin
         state_q     <= IDLE;
         prio_q      <= 1'b0;
         cnt_q       <= 4'd0;
         burst_cut_q <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rd1_q       <= 1'b0;
         own1_q      <= 1'b0;
         rd2_q       <= 1'b0;
         own2_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         prio_q      <= prio_d;
         cnt_q       <= cnt_d;
         burst_cut_q <= cut_d;
         mem_en_q    <= gnt_any;
         mem_we_q    <= gnt_any & we_sel;
         if (gnt_any) begin
            mem_addr_q  <= br_gnt_c ? br_addr  : hc_addr;
            mem_wdata_q <= br_gnt_c ? br_wdata : hc_wdata;
         end
         // Owner tag rides two stages so it lines up with mem_rdata.
         rd1_q  <= gnt_any & ~we_sel;
         own1_q <= hc_gnt_c;
         rd2_q  <= rd1_q;
         own2_q <= own1_q;
         busy_q <= gnt_any | rd1_q;
      end
   end

   assign br_gnt    = br_gnt_c & Rst_UHCI;
   assign hc_gnt    = hc_gnt_c & Rst_UHCI;
   assign br_rvalid = rd2_q & ~own2_q;
   assign hc_rvalid = rd2_q & own2_q;
   assign br_rdata  = br_rvalid ? mem_rdata : '0;
   assign hc_rdata  = hc_rvalid ? mem_rdata : '0;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;
   assign burst_cut = burst_cut_q;

endmodule

// File: tb/tb_usb_mem_arbiter.sv
// Scoreboard bench for usb_mem_arbiter: directed scenarios plus random traffic checked
// against a request-level model of arbitration, memory contents and read ownership.
module tb_usb_mem_arbiter;
   localparam int AW = 8;
   localparam int DW = 32;
   localparam int MB = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          br_req = 0, br_we = 0, hc_req = 0, hc_we = 0, hc_last = 0;
   logic [AW-1:0] br_addr = '0, hc_addr = '0;
   logic [DW-1:0] br_wdata = '0, hc_wdata = '0;
   logic          br_gnt, br_rvalid, hc_gnt, hc_rvalid;
   logic [DW-1:0] br_rdata, hc_rdata;
   logic          mem_en, mem_we, busy, burst_cut;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;

   always #5 clk = ~clk;

   usb_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
      .Clk_UHCI(clk), .Rst_UHCI(rst_n),
      .br_req(br_req), .br_we(br_we), .br_addr(br_addr), .br_wdata(br_wdata),
      .br_gnt(br_gnt), .br_rvalid(br_rvalid), .br_rdata(br_rdata),
      .hc_req(hc_req), .hc_we(hc_we), .hc_last(hc_last), .hc_addr(hc_addr),
      .hc_wdata(hc_wdata), .hc_gnt(hc_gnt), .hc_rvalid(hc_rvalid), .hc_rdata(hc_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy), .burst_cut(burst_cut)
   );

   typedef struct { bit req; bit we; bit last; logic [AW-1:0] addr; logic [DW-1:0] data; } beat_t;
   typedef struct { bit we; logic [AW-1:0] addr; logic [DW-1:0] data; } acc_t;
   typedef struct { bit hc; logic [DW-1:0] data; } ret_t;

   beat_t         plan[$];
   acc_t          acc_q[$];
   ret_t          ret_q[$];
   int            glog[$];
   logic [DW-1:0] ram[256];
   logic [DW-1:0] m_mem[256];
   int            n_cmp = 0, n_fail = 0;
   bit            m_locked = 0, m_prio = 0, exp_cut = 0, rand_mode = 0;
   int            m_beats = 0, cut_cnt = 0;
   logic [DW-1:0] last_br_rdata = '0;
   acc_t          ma;
   ret_t          mr;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Memory device: one-cycle read latency, junk on the bus when not reading.
   always @(posedge clk) begin
      if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
      else mem_rdata <= $urandom;
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_en) begin
            chk("access_expected", acc_q.size() != 0, 1);
            if (acc_q.size() != 0) begin
               ma = acc_q.pop_front();
               chk("mem_we", mem_we, ma.we);
               chk("mem_addr", mem_addr, ma.addr);
               chk("mem_wdata", mem_wdata, ma.data);
            end
         end
         chk("busy", busy, mem_en | br_rvalid | hc_rvalid);
         chk("rvalid_exclusive", br_rvalid & hc_rvalid, 0);
         if (br_rvalid || hc_rvalid) begin
            chk("rvalid_expected", ret_q.size() != 0, 1);
            if (ret_q.size() != 0) begin
               mr = ret_q.pop_front();
               chk("ret_owner", hc_rvalid, mr.hc);
               chk("ret_data", hc_rvalid ? hc_rdata : br_rdata, mr.data);
            end
            if (br_rvalid) last_br_rdata = br_rdata;
         end
         if (!br_rvalid) chk("br_rdata_idle", br_rdata, 0);
         if (!hc_rvalid) chk("hc_rdata_idle", hc_rdata, 0);
      end
   end

   task automatic add_beat(input bit req, input bit we, input bit last,
                           input logic [AW-1:0] addr, input logic [DW-1:0] data);
      beat_t b;
      b.req = req; b.we = we; b.last = last; b.addr = addr; b.data = data;
      plan.push_back(b);
   endtask

   task automatic present();
      if (plan.size() != 0 && plan[0].req) begin
         hc_req = 1; hc_we = plan[0].we; hc_last = plan[0].last;
         hc_addr = plan[0].addr; hc_wdata = plan[0].data;
      end else begin
         hc_req = 0; hc_we = 1'($urandom); hc_last = 1'($urandom);
         hc_addr = 8'($urandom); hc_wdata = $urandom;
      end
   endtask

   task automatic br_issue(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      br_req = 1; br_we = we; br_addr = addr; br_wdata = data;
   endtask

   task automatic random_issue();
      int n;
      if (!br_req && $urandom_range(0, 99) < 45)
         br_issue(1'($urandom), 8'($urandom_range(0, 15)), $urandom);
      if (plan.size() == 0 && $urandom_range(0, 99) < 35) begin
         n = $urandom_range(1, 7);
         for (int i = 0; i < n; i++) begin
            add_beat(1, 1'($urandom), i == n - 1, 8'($urandom_range(0, 15)), $urandom);
            if (i != n - 1 && $urandom_range(0, 99) < 10) add_beat(0, 0, 0, '0, '0);
         end
      end
   endtask

   // One clock: judge this cycle's grants against the model, then advance the requesters.
   task automatic step();
      bit bw, hw, cut, dbg, dhg;
      acc_t a;
      ret_t r;
      @(negedge clk);
      bw = 0; hw = 0; cut = 0;
      if (m_locked) hw = hc_req;
      else if (br_req && hc_req) begin bw = !m_prio; hw = m_prio; end
      else begin bw = br_req; hw = hc_req; end
      chk("br_gnt", br_gnt, bw);
      chk("hc_gnt", hc_gnt, hw);
      chk("burst_cut", burst_cut, exp_cut);
      cut_cnt += int'(burst_cut);
      glog.push_back(bw ? 1 : (hw ? 2 : 0));
      if (bw || hw) begin
         a.we = bw ? br_we : hc_we;
         a.addr = bw ? br_addr : hc_addr;
         a.data = bw ? br_wdata : hc_wdata;
         acc_q.push_back(a);
         if (a.we) m_mem[a.addr] = a.data;
         else begin
            r.hc = hw; r.data = m_mem[a.addr];
            ret_q.push_back(r);
         end
      end
      if (bw) m_prio = 1;
      if (hw) begin
         m_beats = m_locked ? m_beats + 1 : 1;
         if (hc_last || m_beats >= MB) begin
            cut = m_locked && !hc_last;
            m_locked = 0; m_prio = 0;
         end else m_locked = 1;
      end else if (m_locked) begin
         m_locked = 0; m_prio = 0;
      end
      exp_cut = cut;
      dbg = br_gnt; dhg = hc_gnt;
      @(posedge clk);
      #1;
      if (dbg) br_req = 0;
      if (plan.size() != 0 && (!plan[0].req || dhg)) plan.delete(0);
      if (rand_mode) random_issue();
      present();
   endtask

   task automatic drain();
      rand_mode = 0;
      for (int i = 0; i < 100 && (br_req || plan.size() != 0); i++) step();
      repeat (4) step();
      chk("drain_pending", br_req || plan.size() != 0, 0);
      chk("drain_acc", acc_q.size(), 0);
      chk("drain_ret", ret_q.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) begin ram[i] = '0; m_mem[i] = '0; end
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mem_en", mem_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_burst_cut", burst_cut, 0);
      chk("rst_rvalid", {br_rvalid, hc_rvalid}, 0);
      rst_n = 1;

      // Simultaneous single beats after reset: bridge, host controller, bridge.
      glog.delete();
      br_issue(0, 8'h20, '0);
      add_beat(1, 0, 1, 8'h21, '0);
      present();
      step();
      br_issue(0, 8'h22, '0);
      step();
      step();
      chk("rr_0", glog[0], 1);
      chk("rr_1", glog[1], 2);
      chk("rr_2", glog[2], 1);
      drain();

      // Bridge write then read-back of 0x10.
      glog.delete();
      br_issue(1, 8'h10, 32'hA5A5_0001);
      step();
      br_issue(0, 8'h10, '0);
      repeat (3) step();
      chk("br_wr_gnt", glog[0], 1);
      chk("br_rd_gnt", glog[1], 1);
      chk("br_rd_data", last_br_rdata, 32'hA5A5_0001);
      drain();

      // Three-beat burst with the bridge waiting.
      glog.delete(); cut_cnt = 0;
      for (int i = 0; i < 3; i++) add_beat(1, 1, i == 2, 8'(8'h30 + i), $urandom);
      br_issue(1, 8'h38, 32'h1234_5678);
      present();
      repeat (5) step();
      chk("b3_beat1", glog[0], 2);
      chk("b3_beat3", glog[2], 2);
      chk("b3_bridge", glog[3], 1);
      chk("b3_cut", cut_cnt, 0);
      drain();

      // Six-beat burst, cut after beat four.
      glog.delete(); cut_cnt = 0;
      for (int i = 0; i < 6; i++) add_beat(1, i % 2, i == 5, 8'(8'h40 + i), $urandom);
      br_issue(0, 8'h40, '0);
      present();
      repeat (9) step();
      chk("b6_beat4", glog[3], 2);
      chk("b6_bridge", glog[4], 1);
      chk("b6_beat5", glog[5], 2);
      chk("b6_beat6", glog[6], 2);
      chk("b6_cut", cut_cnt, 1);
      drain();

      // Burst hole releases the lock.
      glog.delete();
      add_beat(1, 1, 0, 8'h50, 32'hCAFE_0050);
      add_beat(0, 0, 0, '0, '0);
      present();
      step();
      br_issue(0, 8'h50, '0);
      step();
      step();
      chk("hole_beat", glog[0], 2);
      chk("hole_nogrant", glog[1], 0);
      chk("hole_bridge", glog[2], 1);
      drain();

      rand_mode = 1;
      repeat (600) step();
      drain();

      // Reset one cycle after a host-controller read grant.
      add_beat(1, 0, 1, 8'h03, '0);
      present();
      step();
      br_issue(0, 8'h04, '0);
      rst_n = 0;
      #1;
      chk("rst_mid_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
      chk("rst_mid_gnt", {br_gnt, hc_gnt}, 0);
      chk("rst_mid_ret", {br_rvalid, hc_rvalid, br_rdata, hc_rdata}, 0);
      chk("rst_mid_busy", {busy, burst_cut}, 0);
      acc_q.delete(); ret_q.delete();
      m_locked = 0; m_prio = 0; exp_cut = 0;
      br_req = 0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1;
      repeat (4) step();
      glog.delete();
      br_issue(0, 8'h05, '0);
      add_beat(1, 0, 1, 8'h06, '0);
      present();
      step();
      chk("prio_after_reset", glog[0], 1);
      drain();

      rand_mode = 1;
      repeat (200) step();
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
